// File: rtl/dsp_fe_pkg.sv
// dsp_fe_pkg: shared buffer states, PRBS7 constants and frame-count width for the DSP front end.
package dsp_fe_pkg;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL} buf_st_e;
    localparam logic [6:0] PRBS7_SEED = 7'h7F;
    // x^7 + x^6 + 1: feedback from state bits 6 and 5
    localparam logic [6:0] PRBS7_TAPS = 7'h60;
    localparam int FCNT_W = 16;
    function automatic logic [6:0] prbs7_step(input logic [6:0] s);
        return {s[5:0], ^(s & PRBS7_TAPS)};
    endfunction
endpackage

// File: rtl/dsp_fe_prbs7_gen.sv
// dsp_fe_prbs7_gen: PRBS7 beat source; sample s is the LFSR state after s+1 steps,
// and the LFSR advances LANE_WIDTH steps per generated beat.
module dsp_fe_prbs7_gen
    import dsp_fe_pkg::*;
#(
    parameter int LANE_WIDTH = 16,
    parameter int ADC_WIDTH  = 6
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_adv,
    output logic [LANE_WIDTH-1:0][ADC_WIDTH-1:0] o_dat
);
    logic [6:0] r_lfsr;
    logic [LANE_WIDTH:0][6:0] w_s;

    always_comb begin
        w_s[0] = r_lfsr;
        for (int s = 0; s < LANE_WIDTH; s++) begin
            w_s[s+1] = prbs7_step(w_s[s]);
            o_dat[s] = w_s[s+1][ADC_WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk)
        r_lfsr <= i_rst ? PRBS7_SEED : i_adv ? w_s[LANE_WIDTH] : r_lfsr;
endmodule

// File: rtl/dsp_fe_lad_pack.sv
// dsp_fe_lad_pack: ping-pong deserialiser packing DES_IN_WIDTH beats into a lane/adc/des frame.
// Define DSP_FE_LAD_PACK_PRBS_EN to add the internal PRBS7 source and i_prbs_mode.
module dsp_fe_lad_pack
    import dsp_fe_pkg::*;
#(
    parameter int LANE_WIDTH   = 16,
    parameter int ADC_WIDTH    = 6,
    parameter int DES_IN_WIDTH = 2
) (
    input  logic                                                   i_clk,
    input  logic                                                   i_rst,
    input  logic                                                   i_clear,
    input  logic [LANE_WIDTH-1:0][ADC_WIDTH-1:0]                   i_dat,
    input  logic                                                   i_valid,
    output logic                                                   o_ready,
    output logic [LANE_WIDTH-1:0][ADC_WIDTH-1:0][DES_IN_WIDTH-1:0] o_dat_lad,
    output logic                                                   o_valid,
    input  logic                                                   i_ready,
    output logic [FCNT_W-1:0]                                      o_frame_cnt
`ifdef DSP_FE_LAD_PACK_PRBS_EN
    ,
    input  logic                                                   i_prbs_mode
`endif
);
    localparam int BW = DES_IN_WIDTH > 1 ? $clog2(DES_IN_WIDTH) : 1;
    typedef logic [LANE_WIDTH-1:0][ADC_WIDTH-1:0][DES_IN_WIDTH-1:0] frame_t;

    frame_t                             r_buf [2];
    buf_st_e                            r_st [2];
    logic                               r_wp, r_rp;
    logic [BW-1:0]                      r_beat;
    logic [FCNT_W-1:0]                  r_frame_cnt;
    logic                               w_wfull, w_wr, w_rd, w_last;
    logic [LANE_WIDTH-1:0][ADC_WIDTH-1:0] w_din;

    assign w_wfull     = r_st[r_wp] == FULL;
    assign o_valid     = r_st[r_rp] == FULL;
    assign w_rd        = o_valid && i_ready;
    assign w_last      = r_beat == BW'(DES_IN_WIDTH - 1);
    assign o_dat_lad   = r_buf[r_rp];
    assign o_frame_cnt = r_frame_cnt;

`ifdef DSP_FE_LAD_PACK_PRBS_EN
    logic                                 r_mode, w_mode;
    logic [LANE_WIDTH-1:0][ADC_WIDTH-1:0] w_prbs;
    // mode is only resampled between frames so a frame never mixes sources
    assign w_mode  = r_beat == '0 ? i_prbs_mode : r_mode;
    assign o_ready = !w_wfull && !w_mode;
    assign w_wr    = w_mode ? !w_wfull : i_valid && o_ready;
    assign w_din   = w_mode ? w_prbs : i_dat;

    always_ff @(posedge i_clk)
        r_mode <= i_rst ? 1'b0 : w_mode;

    dsp_fe_prbs7_gen #(.LANE_WIDTH(LANE_WIDTH), .ADC_WIDTH(ADC_WIDTH)) u_prbs (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_adv (w_wr && w_mode && !i_clear),
        .o_dat (w_prbs)
    );
`else
    assign o_ready = !w_wfull;
    assign w_wr    = i_valid && o_ready;
    assign w_din   = i_dat;
`endif

    // a fill and a drain never target the same buffer: FULL blocks fill, non-FULL blocks drain
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_st        <= '{EMPTY, EMPTY};
            r_buf       <= '{default: '0};
            r_wp        <= 1'b0;
            r_rp        <= 1'b0;
            r_beat      <= '0;
            r_frame_cnt <= '0;
        end else if (i_clear) begin
            r_st   <= '{EMPTY, EMPTY};
            r_wp   <= 1'b0;
            r_rp   <= 1'b0;
            r_beat <= '0;
        end else begin
            if (w_wr) begin
                for (int s = 0; s < LANE_WIDTH; s++)
                    for (int a = 0; a < ADC_WIDTH; a++)
                        r_buf[r_wp][s][a][r_beat] <= w_din[s][a];
                r_st[r_wp] <= w_last ? FULL : FILLING;
                r_beat     <= w_last ? '0 : r_beat + 1'b1;
                r_wp       <= w_last ? !r_wp : r_wp;
            end
            if (w_rd) begin
                r_st[r_rp]  <= EMPTY;
                r_rp        <= !r_rp;
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/dsp_fe_lad_pack.md
DSP_FE_LAD_PACK -- requirements
Module: dsp_fe_lad_pack

Interface
REQ-001 Parameter LANE_WIDTH, default 16, is the number of samples per input beat and the number of output lanes.
REQ-002 Parameter ADC_WIDTH, default 6, is the bits per sample.
REQ-003 Parameter DES_IN_WIDTH, default 2, is the number of input beats per output frame.
REQ-004 i_clk  input  1  is the single clock; all state SHALL be on posedge i_clk.
REQ-005 i_rst  input  1  is a synchronous, active-high reset.
REQ-006 i_clear  input  1  is a synchronous flush of all buffered and partial frames.
REQ-007 i_dat  input  [LANE_WIDTH-1:0][ADC_WIDTH-1:0]  carries a time-ordered beat; i_dat[s] is timestep s of the beat.
REQ-008 i_valid  input  1  qualifies i_dat.
REQ-009 o_ready  output  1  indicates that this block accepts a beat.
REQ-010 o_dat_lad  output  [LANE_WIDTH-1:0][ADC_WIDTH-1:0][DES_IN_WIDTH-1:0]  is the frame in lane/adc/des order.
REQ-011 o_valid  output  1  qualifies o_dat_lad.
REQ-012 i_ready  input  1  is the consumer's acceptance of a frame.
REQ-013 o_frame_cnt  output  16  counts frames delivered.
REQ-014 i_prbs_mode  input  1  selects the internal PRBS source; this port SHALL exist only when the PRBS macro is defined.

Function
REQ-015 A beat SHALL transfer when i_valid && o_ready, and a frame SHALL transfer when o_valid && i_ready.
REQ-016 Beat b (0..DES_IN_WIDTH-1) of a frame, bit a of sample s, SHALL map to o_dat_lad[s][a][b], so that o_dat_lad[l][*][d] is timestep l + d*LANE_WIDTH.
REQ-017 The block SHALL hold two frame buffers (ping-pong), each in state EMPTY, FILLING or FULL.
REQ-018 The first beat accepted into an EMPTY buffer SHALL move it to FILLING.
REQ-019 Acceptance of beat DES_IN_WIDTH-1 SHALL move the buffer from FILLING to FULL and toggle the write pointer.
REQ-020 A frame transfer SHALL move the buffer at the read pointer from FULL to EMPTY and toggle the read pointer.
REQ-021 o_ready SHALL be 1 exactly when the write-pointer buffer is not FULL (registered state, no combinational path from i_ready).
REQ-022 o_valid SHALL be 1 exactly when the read-pointer buffer is FULL.
REQ-023 o_dat_lad SHALL be driven from the read-pointer buffer and SHALL remain stable while o_valid && !i_ready.
REQ-024 Latency: the last beat accepted at cycle N SHALL give o_valid=1 at N+1 when the read buffer is free.
REQ-025 Sustained throughput SHALL be one beat per cycle when i_ready is held 1.
REQ-026 When both buffers are FULL, o_ready SHALL be 0 and no beat SHALL be lost or overwritten.
REQ-027 A frame drain and a beat fill to different buffers in the same cycle SHALL both complete.
REQ-028 o_frame_cnt SHALL increment by 1 per frame transfer and wrap from 16'hFFFF to 0.
REQ-029 i_clear SHALL set both buffers EMPTY, both pointers to 0 and the beat counter to 0 on the next edge, and SHALL NOT clear o_frame_cnt.
REQ-030 i_clear SHALL take priority over a simultaneous beat or frame transfer; that beat is discarded and o_frame_cnt does not increment.

Reset
REQ-031 i_rst SHALL force o_valid=0, o_ready=1 (first cycle after release), o_dat_lad=0, o_frame_cnt=0, pointers=0, beat counter=0 and the LFSR to 7'h7F.
REQ-032 An i_rst asserted mid-frame SHALL discard all partial and full frames and SHALL take priority over i_clear.

Configuration
REQ-033 The macro DSP_FE_LAD_PACK_PRBS_EN SHALL compile in the PRBS source and i_prbs_mode.
REQ-034 With the macro defined and i_prbs_mode=1, o_ready SHALL be 0 and the block SHALL internally generate one beat on every cycle in which the write buffer is not FULL.
REQ-035 The PRBS generator SHALL be a PRBS7 LFSR (x^7+x^6+1) that advances LANE_WIDTH steps per generated beat.
REQ-036 Sample s of a generated beat SHALL be bits [ADC_WIDTH-1:0] of the LFSR state after s+1 steps, with ADC_WIDTH<=7.
REQ-037 A change of i_prbs_mode SHALL take effect only at a frame boundary, with the beat counter at 0.
REQ-038 Without the macro, no LFSR logic and no i_prbs_mode port SHALL exist, and behaviour SHALL equal i_prbs_mode=0.

Structure
REQ-039 The shared package dsp_fe_pkg SHALL hold the buffer-state enum (EMPTY/FILLING/FULL), the PRBS7 seed and taps constants, and the frame-count width.
REQ-040 The PRBS generator SHALL be a single sub-module, dsp_fe_prbs7_gen, instantiated only under the macro.

Verification
REQ-041 After reset, with i_ready=1, send beats with i_dat[s]=s and then i_dat[s]=16+s: o_dat_lad[l][*][d] SHALL equal l+16d, o_valid SHALL be 1 for one cycle, and o_frame_cnt SHALL be 1.
REQ-042 Hold i_ready=0 and stream 6 beats: exactly 4 beats SHALL be accepted, o_ready SHALL be 0, and o_dat_lad SHALL stay stable; after releasing i_ready, 2 ordered frames SHALL be delivered followed by the third.
REQ-043 Continuous i_valid=1 and i_ready=1 for 200 cycles: o_ready SHALL stay 1 and exactly 100 frames SHALL be delivered.
REQ-044 Assert i_clear after 1 beat of a frame and concurrently with a beat: no frame SHALL be emitted, and the next two beats SHALL form a clean frame.
REQ-045 Preload o_frame_cnt to 16'hFFFF via 65535 frames, then deliver one more frame: o_frame_cnt SHALL be 0.
REQ-046 With the macro defined and i_prbs_mode=1 after reset: sample 0 of the first frame SHALL be the low ADC_WIDTH bits of the LFSR state after one step from 7'h7F, and the PRBS7 sequence SHALL be continuous across frames.
